// File: rtl/bridge_unpack_if.sv
// Valid/ready bus for the M-to-N unpacking bridge.
// flush_i exists only when BRIDGE_UNPACK_FLUSH_EN is defined.
interface bridge_unpack_if #(
  parameter int M = 32,
  parameter int N = 8
);
  logic         vld_i;
  logic [M-1:0] din;
  logic         rdy_o;
  logic         vld_o;
  logic [N-1:0] dout;
  logic         rdy_i;
`ifdef BRIDGE_UNPACK_FLUSH_EN
  logic         flush_i;

  modport master (output vld_i, din, rdy_i, flush_i, input rdy_o, vld_o, dout);
  modport slave  (input vld_i, din, rdy_i, flush_i, output rdy_o, vld_o, dout);
`else
  modport master (output vld_i, din, rdy_i, input rdy_o, vld_o, dout);
  modport slave  (input vld_i, din, rdy_i, output rdy_o, vld_o, dout);
`endif
endinterface

// File: rtl/bridge_unpack.sv
// M-bit to N-bit width down-converter over one continuous MSB-first bit stream.
// Optional flush of residual bits is enabled by defining BRIDGE_UNPACK_FLUSH_EN.
module bridge_unpack #(
  parameter int M = 32,
  parameter int N = 8
) (
  input logic           clk,
  input logic           rst_n,
  bridge_unpack_if.slave bus
);

  localparam int BUF_W     = M + 2*N;
  localparam int CNT_WIDTH = $clog2(M + 2*N + 1);

  localparam logic [CNT_WIDTH-1:0] C_N  = CNT_WIDTH'(N);
  localparam logic [CNT_WIDTH-1:0] C_2N = CNT_WIDTH'(2*N);
  localparam logic [CNT_WIDTH-1:0] C_M  = CNT_WIDTH'(M);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
`ifdef BRIDGE_UNPACK_FLUSH_EN
  localparam logic [1:0] S_FLUSH = 2'd2;
`endif

  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [BUF_W-1:0]     r_buf;

  logic                 w_vld;
  logic                 w_rdy;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic [CNT_WIDTH-1:0] w_cnt_a;
  logic [BUF_W-1:0]     w_buf_a;
  logic [CNT_WIDTH-1:0] w_shamt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [BUF_W-1:0]     w_buf_nxt;
  logic [1:0]           w_state_nxt;

  // Handshake outputs decode from state registers only, never from vld_i/rdy_i.
  always_comb begin
    w_vld = 1'b0;
    w_rdy = 1'b0;
    case (r_state)
      S_RUN: begin
        w_vld = (r_cnt >= C_N);
        w_rdy = (r_cnt < C_2N);
      end
`ifdef BRIDGE_UNPACK_FLUSH_EN
      S_FLUSH: w_vld = (r_cnt != '0);
`endif
      default: ;
    endcase
  end

  assign bus.vld_o = w_vld;
  assign bus.rdy_o = w_rdy;
  assign bus.dout  = r_buf[BUF_W-1 -: N];

  assign w_out_fire = w_vld & bus.rdy_i;
  assign w_in_fire  = bus.vld_i & w_rdy;

  // Drain first, then append the new word right below the surviving valid bits.
  // A flushed residual (cnt < N) empties the counter entirely.
  always_comb begin
    w_buf_a = r_buf;
    w_cnt_a = r_cnt;
    if (w_out_fire) begin
      w_buf_a = r_buf << N;
      w_cnt_a = (r_cnt >= C_N) ? (r_cnt - C_N) : '0;
    end
    w_shamt   = C_2N - w_cnt_a;
    w_buf_nxt = w_buf_a;
    w_cnt_nxt = w_cnt_a;
    if (w_in_fire) begin
      w_buf_nxt = w_buf_a | (BUF_W'(bus.din) << w_shamt);
      w_cnt_nxt = w_cnt_a + C_M;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT: w_state_nxt = S_RUN;
`ifdef BRIDGE_UNPACK_FLUSH_EN
      S_RUN: begin
        if (bus.flush_i) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if ((r_cnt == '0) || (w_out_fire && (r_cnt <= C_N))) w_state_nxt = S_RUN;
      end
`else
      S_RUN: w_state_nxt = S_RUN;
`endif
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    r_cnt <= CNT_WIDTH'(BUF_W - 1));

endmodule

// File: tb/tb_bridge_unpack.sv
// Directed bench for bridge_unpack: one M=32/N=8 and one M=12/N=8 instance.
// Flush scenario is compiled in only with BRIDGE_UNPACK_FLUSH_EN.
module tb_bridge_unpack;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;

  bridge_unpack_if #(.M(32), .N(8)) if32 ();
  bridge_unpack_if #(.M(12), .N(8)) if12 ();

  bridge_unpack #(.M(32), .N(8)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  bridge_unpack #(.M(12), .N(8)) u_dut12 (.clk(clk), .rst_n(rst_n), .bus(if12));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    if32.vld_i = 1'b0; if32.din = '0; if32.rdy_i = 1'b0;
    if12.vld_i = 1'b0; if12.din = '0; if12.rdy_i = 1'b0;
`ifdef BRIDGE_UNPACK_FLUSH_EN
    if32.flush_i = 1'b0;
    if12.flush_i = 1'b0;
`endif
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    if32.vld_i = 1'b1; if32.din = 32'h11223344;
    tick();
    testsRun++; if (if32.rdy_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rdy: got %b want 0", if32.rdy_o); end
    testsRun++; if (if32.vld_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_vld: got %b want 0", if32.vld_o); end
    testsRun++; if (if32.dout !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_dout: got %h want 00", if32.dout); end
    testsRun++; if (u_dut32.r_cnt !== 6'd0) begin testsFailed++; $display("[TB] FAIL reset_cnt: got %0d want 0", u_dut32.r_cnt); end
    rst_n = 1'b1;
    #1;
    testsRun++; if (if32.rdy_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL init_rdy: got %b want 0", if32.rdy_o); end
    tick();
    testsRun++; if (if32.rdy_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL run_rdy: got %b want 1", if32.rdy_o); end
    testsRun++; if (if32.vld_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL pre_fire_vld: got %b want 0", if32.vld_o); end
    tick();
    if32.vld_i = 1'b0;
    testsRun++; if (if32.vld_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL first_vld: got %b want 1", if32.vld_o); end
    testsRun++; if (if32.dout !== 8'h11) begin testsFailed++; $display("[TB] FAIL first_dout: got %h want 11", if32.dout); end
  endtask

  task automatic test_stream32;
    logic [31:0] words [2];
    logic [7:0]  expB [8];
    int          fi;
    logic        inTake;
    words = '{32'h11223344, 32'h55667788};
    expB  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_reset();
    fi = 0;
    if32.rdy_i = 1'b1;
    if32.vld_i = 1'b1; if32.din = words[0];
    inTake = if32.vld_i & if32.rdy_o;
    tick();
    if (inTake) fi++;
    if32.vld_i = (fi < 2); if32.din = (fi < 2) ? words[fi] : '0;
    for (int i = 0; i < 8; i++) begin
      testsRun++; if (if32.vld_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL stream32_vld[%0d]: got %b want 1", i, if32.vld_o); end
      testsRun++; if (if32.dout !== expB[i]) begin testsFailed++; $display("[TB] FAIL stream32_dout[%0d]: got %h want %h", i, if32.dout, expB[i]); end
      inTake = if32.vld_i & if32.rdy_o;
      tick();
      if (inTake) fi++;
      if32.vld_i = (fi < 2); if32.din = (fi < 2) ? words[fi] : '0;
    end
    testsRun++; if (if32.vld_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL stream32_end_vld: got %b want 0", if32.vld_o); end
  endtask

  task automatic test_stream12;
    do_reset();
    if12.rdy_i = 1'b1;
    if12.vld_i = 1'b1; if12.din = 12'hABC;
    tick();
    testsRun++; if (if12.dout !== 8'hAB || if12.vld_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL stream12_ab: got vld=%b dout=%h want 1/ab", if12.vld_o, if12.dout); end
    testsRun++; if (if12.rdy_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL stream12_rdy: got %b want 1", if12.rdy_o); end
    if12.din = 12'hDEF;
    tick();
    if12.vld_i = 1'b0;
    testsRun++; if (if12.dout !== 8'hCD || if12.vld_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL stream12_cd: got vld=%b dout=%h want 1/cd", if12.vld_o, if12.dout); end
    tick();
    testsRun++; if (if12.dout !== 8'hEF || if12.vld_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL stream12_ef: got vld=%b dout=%h want 1/ef", if12.vld_o, if12.dout); end
    tick();
    testsRun++; if (if12.vld_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL stream12_end_vld: got %b want 0", if12.vld_o); end
    testsRun++; if (u_dut12.r_cnt !== 5'd0) begin testsFailed++; $display("[TB] FAIL stream12_cnt: got %0d want 0", u_dut12.r_cnt); end
  endtask

  task automatic test_backpressure;
    logic [31:0] words [3];
    logic [7:0]  expB [12];
    int          fi;
    int          k;
    int          cyc;
    logic        inTake;
    words = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    expB  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    do_reset();
    fi = 0;
    if32.rdy_i = 1'b0;
    if32.vld_i = 1'b1; if32.din = words[0];
    for (int i = 0; i < 10; i++) begin
      inTake = if32.vld_i & if32.rdy_o;
      tick();
      if (inTake) fi++;
      if32.vld_i = (fi < 3); if32.din = (fi < 3) ? words[fi] : '0;
      testsRun++; if (if32.vld_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_vld[%0d]: got %b want 1", i, if32.vld_o); end
      testsRun++; if (if32.dout !== 8'h11) begin testsFailed++; $display("[TB] FAIL bp_dout[%0d]: got %h want 11", i, if32.dout); end
      testsRun++; if (if32.rdy_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_rdy[%0d]: got %b want 0", i, if32.rdy_o); end
    end
    if32.rdy_i = 1'b1;
    k = 0;
    cyc = 0;
    while (k < 12 && cyc < 40) begin
      if (if32.vld_o && if32.rdy_i) begin
        testsRun++; if (if32.dout !== expB[k]) begin testsFailed++; $display("[TB] FAIL bp_seq[%0d]: got %h want %h", k, if32.dout, expB[k]); end
        k++;
      end
      inTake = if32.vld_i & if32.rdy_o;
      tick();
      if (inTake) fi++;
      if32.vld_i = (fi < 3); if32.din = (fi < 3) ? words[fi] : '0;
      cyc++;
    end
    testsRun++; if (k != 12) begin testsFailed++; $display("[TB] FAIL bp_timeout: got %0d bytes want 12", k); end
    testsRun++; if (if32.vld_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_end_vld: got %b want 0", if32.vld_o); end
  endtask

  task automatic test_reset_midstream;
    do_reset();
    if12.rdy_i = 1'b0;
    if12.vld_i = 1'b1; if12.din = 12'hABC;
    tick();
    if12.din = 12'hDEF;
    tick();
    if12.vld_i = 1'b0; if12.rdy_i = 1'b1;
    tick();
    tick();
    if12.rdy_i = 1'b0;
    if12.vld_i = 1'b1; if12.din = 12'h111;
    tick();
    if12.vld_i = 1'b0;
    testsRun++; if (u_dut12.r_cnt !== 5'd20) begin testsFailed++; $display("[TB] FAIL mid_cnt20: got %0d want 20", u_dut12.r_cnt); end
    #2 rst_n = 1'b0;
    #1;
    testsRun++; if (if12.vld_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_rst_vld: got %b want 0", if12.vld_o); end
    testsRun++; if (u_dut12.r_cnt !== 5'd0) begin testsFailed++; $display("[TB] FAIL mid_rst_cnt: got %0d want 0", u_dut12.r_cnt); end
    tick();
    rst_n = 1'b1;
    tick();
    testsRun++; if (if12.rdy_o !== 1'b1 || if12.vld_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_run: got rdy=%b vld=%b want 1/0", if12.rdy_o, if12.vld_o); end
    if12.rdy_i = 1'b1;
    if12.vld_i = 1'b1; if12.din = 12'h123;
    tick();
    testsRun++; if (if12.dout !== 8'h12 || if12.vld_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_new12: got vld=%b dout=%h want 1/12", if12.vld_o, if12.dout); end
    if12.din = 12'h456;
    tick();
    if12.vld_i = 1'b0;
    testsRun++; if (if12.dout !== 8'h34 || if12.vld_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_new34: got vld=%b dout=%h want 1/34", if12.vld_o, if12.dout); end
    tick();
    testsRun++; if (if12.dout !== 8'h56 || if12.vld_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_new56: got vld=%b dout=%h want 1/56", if12.vld_o, if12.dout); end
    tick();
    testsRun++; if (if12.vld_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_end_vld: got %b want 0", if12.vld_o); end
  endtask

`ifdef BRIDGE_UNPACK_FLUSH_EN
  task automatic test_flush;
    do_reset();
    if12.rdy_i = 1'b1;
    if12.vld_i = 1'b1; if12.din = 12'hABC;
    tick();
    testsRun++; if (if12.dout !== 8'hAB || if12.vld_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL flush_ab: got vld=%b dout=%h want 1/ab", if12.vld_o, if12.dout); end
    if12.vld_i = 1'b0;
    if12.flush_i = 1'b1;
    tick();
    if12.flush_i = 1'b0;
    testsRun++; if (if12.rdy_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_rdy: got %b want 0", if12.rdy_o); end
    testsRun++; if (if12.dout !== 8'hC0 || if12.vld_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL flush_c0: got vld=%b dout=%h want 1/c0", if12.vld_o, if12.dout); end
    tick();
    testsRun++; if (if12.vld_o !== 1'b0 || if12.rdy_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL flush_back_run: got vld=%b rdy=%b want 0/1", if12.vld_o, if12.rdy_o); end
    testsRun++; if (u_dut12.r_cnt !== 5'd0) begin testsFailed++; $display("[TB] FAIL flush_cnt: got %0d want 0", u_dut12.r_cnt); end
  endtask
`endif

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b1;
    idle_inputs();
    test_reset();
    test_stream32();
    test_stream12();
    test_backpressure();
    test_reset_midstream();
`ifdef BRIDGE_UNPACK_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
